// File: rtl/mod2617_pkg.sv
// Shared constants and types for the mod-2617 multiply path (multiplier and
// Barrett reducer).
package mod2617_pkg;

  localparam int Q  = 2617;  // modulus
  localparam int W  = 12;    // operand width
  localparam int PW = 23;    // product width, equal to the reducer input width
  localparam int CW = 4;     // multiplier bit counter width

  // Modulus at operand width, for range checks without width mixing
  localparam logic [W-1:0]  Q_W      = W'(Q);
  // Counter value of the last multiplier bit processed in RUN
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_2617_seq.sv
// Iterative shift-add multiplier for residues mod 2617. One multiplier bit is
// consumed per cycle; the 23-bit product is held until the consumer takes it.
// Operands at or above the modulus yield a zero product with dout_err set.
module mul_2617_seq
  import mod2617_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  din_a,
  input  logic [W-1:0]  din_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] dout_p,
  output logic          dout_err
);

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [PW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          err_q;

  logic          accept;
  logic          in_err;
  logic [W-1:0]  b_shift;
  logic [PW-1:0] addend;

  // Handshake, range check and the shifted partial product for this cycle
  // NOTE: every combinational output is fully assigned here, so no latch can form.
  always_comb begin
    in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    accept   = in_valid && in_ready;
    in_err   = (din_a >= Q_W) || (din_b >= Q_W);
    b_shift  = b_q >> cnt;
    addend   = PW'(a_q) << cnt;
  end

  // Sequencer and datapath: load on accept, add one partial product per RUN cycle
  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      // An operand error skips RUN entirely and reports a zero product
      a_q   <= din_a;
      b_q   <= din_b;
      acc   <= '0;
      cnt   <= '0;
      err_q <= in_err;
      state <= in_err ? DONE : RUN;
    end else begin
      case (state)
        RUN: begin
          if (b_shift[0]) acc <= acc + addend;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_BIT) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= state;
      endcase
    end
  end

  // Outputs come straight from registers, so they cannot glitch while DONE holds
  always_comb begin
    out_valid = (state == DONE);
    dout_p    = acc;
    dout_err  = err_q;
  end

endmodule

// File: tb/tb_mul_2617_seq.sv
// Self-checking bench for mul_2617_seq: directed corner cases plus a random
// sweep against a plain-arithmetic reference model.
module tb_mul_2617_seq;

  localparam int Q  = 2617;
  localparam int W  = 12;
  localparam int PW = 23;
  localparam int TIMEOUT = 60;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  din_a;
  logic [W-1:0]  din_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] dout_p;
  logic          dout_err;

  int total = 0;
  int bad   = 0;

  mul_2617_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .din_b     (din_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_p    (dout_p),
    .dout_err  (dout_err)
  );

  always #5 clk = ~clk;

  // Reference model: product of legal residues, zero with error otherwise
  function automatic void model(input int a, input int b,
                                output logic [PW-1:0] p, output logic e);
    e = (a >= Q) || (b >= Q);
    p = e ? '0 : PW'(a * b);
  endfunction

  // Wait (at negedges) until in_ready, bounded
  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL %s: in_ready never rose within %0d cycles", name, TIMEOUT);
    end
  endtask

  // Present a pair at a negedge; returns after the accepting posedge, at the next negedge,
  // with in_valid dropped. Leaves out_ready as given.
  task automatic present(input int a, input int b);
    din_a    = W'(a);
    din_b    = W'(b);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count cycles after the accept edge until out_valid shows up, bounded
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full transaction with result and latency checks; drains with a one-cycle out_ready pulse
  task automatic run_op(input string name, input int a, input int b, input int exp_lat);
    logic [PW-1:0] exp_p;
    logic          exp_e;
    int            lat;
    model(a, b, exp_p, exp_e);
    wait_ready(name);
    out_ready = 1'b0;
    present(a, b);
    wait_result(lat);
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL %s timeout: out_valid not seen after %0d cycles", name, lat);
    end else begin
      if (dout_p !== exp_p || dout_err !== exp_e) begin
        bad++;
        $display("FAIL %s result: a=%0d b=%0d got p=%0d err=%0b want p=%0d err=%0b",
                 name, a, b, dout_p, dout_err, exp_p, exp_e);
      end
      if (exp_lat >= 0) begin
        total++;
        if (lat != exp_lat) begin
          bad++;
          $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din_a = '0; din_b = '0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout_p !== '0 || dout_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: in_ready=%0b out_valid=%0b p=%0d err=%0b want 1 0 0 0",
               in_ready, out_valid, dout_p, dout_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_corners();
    run_op("max",      2616, 2616, 12);
    run_op("zero_a",   0,    1234, 12);
    run_op("one_a",    1,    2616, 12);
    run_op("one_b",    1234, 1,    12);
    run_op("zero_b",   2616, 0,    12);
    // Error pairs go to DONE on the accept edge itself
    run_op("err_a",    2617, 5,    0);
    run_op("err_b4095",2617, 4095, 0);
    run_op("err_b",    7,    2617, 0);
  endtask

  task automatic test_backpressure();
    int lat;
    wait_ready("bp");
    out_ready = 1'b0;
    present(100, 200);
    wait_result(lat);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (out_valid !== 1'b1 || dout_p !== PW'(20000) || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp hold[%0d]: out_valid=%0b p=%0d in_ready=%0b want 1 20000 0",
                 i, out_valid, dout_p, in_ready);
      end
      @(negedge clk);
    end
    // Consumer takes the result while the next pair is waiting
    out_ready = 1'b1;
    din_a = W'(3); din_b = W'(7); in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp in_ready comb: got %0b want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp chained accept: out_valid=%0b want 0", out_valid);
    end
    wait_result(lat);
    total++;
    if (!out_valid || dout_p !== PW'(21) || lat != 12) begin
      bad++;
      $display("FAIL bp chained result: valid=%0b p=%0d lat=%0d want 1 21 12",
               out_valid, dout_p, lat);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    // out_ready held high with the next pair always waiting: one product per 13 cycles
    int a_v[4] = '{2616, 77, 2617, 1500};
    int b_v[4] = '{3, 2616, 9, 1501};
    logic [PW-1:0] exp_p;
    logic          exp_e;
    int            gap;
    wait_ready("b2b");
    out_ready = 1'b1;
    din_a = W'(a_v[0]); din_b = W'(b_v[0]); in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        din_a = W'(a_v[i+1]); din_b = W'(b_v[i+1]);
      end else begin
        in_valid = 1'b0;
      end
      gap = 0;
      while (!out_valid && gap < TIMEOUT) begin
        @(negedge clk);
        gap++;
      end
      model(a_v[i], b_v[i], exp_p, exp_e);
      total++;
      if (!out_valid || dout_p !== exp_p || dout_err !== exp_e) begin
        bad++;
        $display("FAIL b2b[%0d]: valid=%0b p=%0d err=%0b want p=%0d err=%0b",
                 i, out_valid, dout_p, dout_err, exp_p, exp_e);
      end
      total++;
      if (gap != (exp_e ? 0 : 12)) begin
        bad++;
        $display("FAIL b2b[%0d] spacing: got %0d want %0d", i, gap, exp_e ? 0 : 12);
      end
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b drain: out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    wait_ready("rst_run");
    out_ready = 1'b0;
    present(1000, 1000);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout_p !== '0 || dout_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_run: out_valid=%0b in_ready=%0b p=%0d err=%0b want 0 1 0 0",
               out_valid, in_ready, dout_p, dout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 50, 60, 12);
  endtask

  task automatic test_reset_mid_done();
    int lat;
    wait_ready("rst_done");
    out_ready = 1'b0;
    present(2617, 1);
    wait_result(lat);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || dout_err !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_done: out_valid=%0b err=%0b in_ready=%0b want 0 0 1",
               out_valid, dout_err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int a, b;
      a = ($urandom_range(0, 15) == 0) ? $urandom_range(Q, 4095) : $urandom_range(0, Q - 1);
      b = ($urandom_range(0, 15) == 0) ? $urandom_range(Q, 4095) : $urandom_range(0, Q - 1);
      run_op("rand", a, b, ((a >= Q) || (b >= Q)) ? 0 : 12);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_mid_done();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
